// File: rtl/mux_sel_sequencer.sv
// -----------------------------------------------------------------------------
// mux_sel_sequencer
//
// Round-robin select generator for a 4x1 mux. Four request lines compete for
// the mux; one channel is granted at a time and keeps the mux for DWELL cycles
// before rotation is considered. All outputs are registered.
//
// Parameters
//   DWELL : cycles a granted channel keeps the mux before rotation (1..2^CW-1)
//   CW    : width of the dwell counter
//
// Ports
//   clk_i   : clock, all state updates on the rising edge
//   rst_i   : synchronous active-high reset
//   en_i    : sequencer enable; 0 drops any grant and forces IDLE
//   req_i   : channel requests, bit0=a .. bit3=d
//   hold_i  : blocks dwell-expiry rotation (not release on dropped req/en)
//   s1_o    : mux select MSB, index = {s1_o, s2_o}
//   s2_o    : mux select LSB
//   gnt_o   : one-hot grant, 0000 when not valid
//   valid_o : a channel is granted and s1_o/s2_o are meaningful
//   sw_o    : one-cycle pulse on the first cycle of every new grant
// -----------------------------------------------------------------------------
module mux_sel_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [3:0] req_i,
    input  logic       hold_i,
    output logic       s1_o,
    output logic       s2_o,
    output logic [3:0] gnt_o,
    output logic       valid_o,
    output logic       sw_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
    localparam logic [CW-1:0] DWELL_CNT = CW'(DWELL);

    state_e        state_q, state_d;
    logic [1:0]    last_q,  last_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    sel_q,   sel_d;
    logic [3:0]    gnt_q,   gnt_d;
    logic          valid_q, valid_d;
    logic          sw_q,    sw_d;

    logic [2:0]    win_s;
    logic          found_s;
    logic [1:0]    winner_s;

    // Search order ptr+1, ptr+2, ptr+3, ptr. Scanning from farthest to nearest
    // lets the nearest set request overwrite the result last.
    // Returns {found, index}.
    function automatic logic [2:0] rr_search(input logic [3:0] req,
                                             input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + k[1:0];
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Index to one-hot grant vector.
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    // Round-robin winner relative to the last granted channel.
    always_comb begin
        win_s    = rr_search(req_i, last_q);
        found_s  = win_s[2];
        winner_s = win_s[1:0];
    end

    // Next-state and output decode; sw defaults low so it only pulses.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        sw_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_i && found_s) begin
                    state_d = ST_GRANT;
                    last_d  = winner_s;
                    sel_d   = winner_s;
                    gnt_d   = onehot4(winner_s);
                    valid_d = 1'b1;
                    sw_d    = 1'b1;
                    cnt_d   = {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    // Select lines keep their last value while idle.
                    valid_d = 1'b0;
                    gnt_d   = 4'b0000;
                end
            end

            ST_GRANT: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    gnt_d   = 4'b0000;
                end else if (!req_i[last_q]) begin
                    // Current owner dropped: any other requester wins now,
                    // and the winner necessarily differs from the owner.
                    if (found_s) begin
                        last_d  = winner_s;
                        sel_d   = winner_s;
                        gnt_d   = onehot4(winner_s);
                        valid_d = 1'b1;
                        sw_d    = 1'b1;
                        cnt_d   = {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        gnt_d   = 4'b0000;
                    end
                end else if ((cnt_q >= DWELL_CNT) && !hold_i) begin
                    cnt_d = {{(CW-1){1'b0}}, 1'b1};
                    if (winner_s != last_q) begin
                        last_d  = winner_s;
                        sel_d   = winner_s;
                        gnt_d   = onehot4(winner_s);
                        sw_d    = 1'b1;
                    end else begin
                        // Sole requester: re-arm the dwell without a strobe.
                        sw_d = 1'b0;
                    end
                end else begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous reset; the pointer resets
    // to 3 so the first search starts at channel 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            last_q  <= 2'd3;
            cnt_q   <= {CW{1'b0}};
            sel_q   <= 2'b00;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            sw_q    <= sw_d;
        end
    end

    assign s1_o    = sel_q[1];
    assign s2_o    = sel_q[0];
    assign gnt_o   = gnt_q;
    assign valid_o = valid_q;
    assign sw_o    = sw_q;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer (DWELL=4, CW=8). Each stimulus
// vector is applied on the falling edge and its hand-computed expected
// post-edge outputs are queued; a monitor pops one entry 1ns after each
// rising edge and compares.
module tb_mux_sel_sequencer;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic       hold;
    logic       s1;
    logic       s2;
    logic [3:0] gnt;
    logic       valid;
    logic       sw;

    typedef struct {
        int         id;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       valid;
        logic       sw;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   vec_id   = 0;

    mux_sel_sequencer #(.DWELL(4), .CW(8)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .en_i    (en),
        .req_i   (req),
        .hold_i  (hold),
        .s1_o    (s1),
        .s2_o    (s2),
        .gnt_o   (gnt),
        .valid_o (valid),
        .sw_o    (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one input vector and queue the outputs expected after the edge.
    task automatic vec(input logic r, input logic e, input logic [3:0] rq,
                       input logic h, input logic [1:0] esel,
                       input logic [3:0] egnt, input logic ev, input logic esw);
        exp_t x;
        @(negedge clk);
        rst  = r;
        en   = e;
        req  = rq;
        hold = h;
        x.id    = vec_id;
        x.sel   = esel;
        x.gnt   = egnt;
        x.valid = ev;
        x.sw    = esw;
        exp_q.push_back(x);
        vec_id++;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                n_checks++;
                if ({s1, s2} !== x.sel || gnt !== x.gnt || valid !== x.valid || sw !== x.sw) begin
                    n_errors++;
                    $display("FAIL vec%0d: got sel=%b gnt=%b valid=%b sw=%b, expected sel=%b gnt=%b valid=%b sw=%b",
                             x.id, {s1, s2}, gnt, valid, sw, x.sel, x.gnt, x.valid, x.sw);
                end
            end
        end
    end

    initial begin
        logic [1:0] ch;
        rst = 1'b1; en = 1'b0; req = 4'b0000; hold = 1'b0;

        // Reset held with all requests pending: outputs stay cleared.
        vec(1, 1, 4'b1111, 0, 2'b00, 4'b0000, 0, 0);
        vec(1, 1, 4'b1111, 0, 2'b00, 4'b0000, 0, 0);

        // Round robin with all requesters: each channel for 4 cycles,
        // starting at channel 0 on the first edge after reset.
        for (int i = 0; i < 5; i++) begin
            ch = 2'(i);
            for (int k = 0; k < 4; k++) begin
                vec(0, 1, 4'b1111, 0, ch, 4'b0001 << ch, 1, (k == 0));
            end
        end

        // Sole requester from IDLE: one strobe, then kept with sw=0.
        vec(1, 1, 4'b0001, 0, 2'b00, 4'b0000, 0, 0);
        vec(0, 1, 4'b0001, 0, 2'b00, 4'b0001, 1, 1);
        for (int i = 0; i < 22; i++) begin
            vec(0, 1, 4'b0001, 0, 2'b00, 4'b0001, 1, 0);
        end

        // Owner drops to another requester: immediate switch to ch2.
        vec(0, 1, 4'b0100, 0, 2'b10, 4'b0100, 1, 1);
        vec(0, 1, 4'b0100, 0, 2'b10, 4'b0100, 1, 0);
        // All requests drop at grant cycle 2: release, select holds 10.
        vec(0, 1, 4'b0000, 0, 2'b10, 4'b0000, 0, 0);
        vec(0, 1, 4'b0000, 0, 2'b10, 4'b0000, 0, 0);
        // Re-request: regrant of the same channel strobes sw.
        vec(0, 1, 4'b0100, 0, 2'b10, 4'b0100, 1, 1);

        // hold keeps ch1 past the dwell, release rotates to ch3.
        vec(1, 1, 4'b1010, 1, 2'b00, 4'b0000, 0, 0);
        vec(0, 1, 4'b1010, 1, 2'b01, 4'b0010, 1, 1);
        for (int i = 0; i < 10; i++) begin
            vec(0, 1, 4'b1010, 1, 2'b01, 4'b0010, 1, 0);
        end
        vec(0, 1, 4'b1010, 0, 2'b11, 4'b1000, 1, 1);

        // ch3 drops, search from 3 finds ch2; then en=0 mid-grant.
        vec(0, 1, 4'b0100, 0, 2'b10, 4'b0100, 1, 1);
        vec(0, 1, 4'b1111, 0, 2'b10, 4'b0100, 1, 0);
        vec(0, 0, 4'b1111, 0, 2'b10, 4'b0000, 0, 0);
        vec(0, 1, 4'b1111, 0, 2'b11, 4'b1000, 1, 1);

        // Reset pulse mid-grant: pointer back to 3, next grant is ch0.
        vec(0, 1, 4'b1111, 0, 2'b11, 4'b1000, 1, 0);
        vec(1, 1, 4'b1111, 0, 2'b00, 4'b0000, 0, 0);
        vec(0, 1, 4'b1111, 0, 2'b00, 4'b0001, 1, 1);

        // hold does not block release: dropped owner switches, then idles.
        vec(0, 1, 4'b0010, 1, 2'b01, 4'b0010, 1, 1);
        vec(0, 1, 4'b0000, 1, 2'b01, 4'b0000, 0, 0);

        // Counter saturation: ch0 held 255 further cycles. A wrapping
        // counter would read 0 at release and not rotate.
        vec(0, 1, 4'b0011, 1, 2'b00, 4'b0001, 1, 1);
        for (int i = 0; i < 255; i++) begin
            vec(0, 1, 4'b0011, 1, 2'b00, 4'b0001, 1, 0);
        end
        vec(0, 1, 4'b0011, 0, 2'b01, 4'b0010, 1, 1);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
        end
        if (n_checks != vec_id) begin
            n_errors++;
            $display("FAIL count: got %0d checks, expected %0d", n_checks, vec_id);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
